// File: rtl/kv_txn_sequencer.sv
// kv_txn_sequencer: frames 9-byte packets (opcode, key, value) and applies them to an on-chip account table.
// Ports:
//   tick_in  clock, rising edge
//   rst      asynchronous active-high reset
//   rx_byte  packet byte, valid while newbyt is high
//   newbyt   byte strobe, one byte per cycle
//   busy     scanning or executing; incoming bytes are discarded
//   drop     one-cycle pulse after a byte was discarded while busy
//   done     one-cycle result pulse
//   signal   0 none, 1 created, 2 transacted, 3 error (held until next done)
//   err      0 ok, 1 dup key, 2 full, 3 unknown key, 4 funds, 5 bad opcode, 6 overflow
//   key      key of the last completed packet
//   value    resulting balance (current balance on error when the key exists, else 0)
module kv_txn_sequencer #(
    parameter int ENTRIES = 8,
    parameter int KEY_W   = 32,
    parameter int VAL_W   = 32
) (
    input  logic             tick_in,
    input  logic             rst,
    input  logic [7:0]       rx_byte,
    input  logic             newbyt,
    output logic             busy,
    output logic             drop,
    output logic             done,
    output logic [1:0]       signal,
    output logic [2:0]       err,
    output logic [KEY_W-1:0] key,
    output logic [VAL_W-1:0] value
);
    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, SEARCH, EXEC} state_t;

    state_t             state, state_nx;
    logic [2:0]         cnt;
    logic [1:0]         op;
    logic [KEY_W-1:0]   pkt_key;
    logic [VAL_W-1:0]   pkt_val;
    logic [IW-1:0]      idx, hit_idx, free_idx;
    logic               hit, has_free;
    logic [KEY_W-1:0]   tkey [ENTRIES];
    logic [VAL_W-1:0]   tval [ENTRIES];
    logic [ENTRIES-1:0] tvalid;

    logic               op_ok, last_byte, scan_end;
    logic [VAL_W-1:0]   cur;
    logic [VAL_W:0]     sum, diff;
    logic               wr_en;
    logic [IW-1:0]      wr_idx;
    logic [VAL_W-1:0]   wr_val, ex_val;
    logic [2:0]         ex_err;
    logic [1:0]         ex_sig;

    assign op_ok     = rx_byte == 8'h01 || rx_byte == 8'h02 || rx_byte == 8'h03;
    assign last_byte = state == COLLECT && newbyt && cnt == 3'd7;
    assign scan_end  = idx == IW'(ENTRIES - 1);
    assign busy      = state == SEARCH || state == EXEC;

    // 33-bit arithmetic: the carry/borrow bit flags overflow or insufficient funds
    assign cur  = tval[hit_idx];
    assign sum  = {1'b0, cur} + {1'b0, pkt_val};
    assign diff = {1'b0, cur} - {1'b0, pkt_val};

    always_ff @(posedge tick_in or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (newbyt && op_ok) ? COLLECT : IDLE;
            COLLECT: state_nx = last_byte ? SEARCH : COLLECT;
            SEARCH:  state_nx = scan_end ? EXEC : SEARCH;
            EXEC:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ex_err = 3'd0;
        wr_en  = 1'b0;
        wr_idx = hit_idx;
        wr_val = cur;
        case (op)
            2'd1: begin
                if (hit)            ex_err = 3'd1;
                else if (!has_free) ex_err = 3'd2;
                else begin
                    wr_en  = 1'b1;
                    wr_idx = free_idx;
                    wr_val = pkt_val;
                end
            end
            2'd2: begin
                if (!hit)             ex_err = 3'd3;
                else if (sum[VAL_W])  ex_err = 3'd6;
                else begin
                    wr_en  = 1'b1;
                    wr_val = sum[VAL_W-1:0];
                end
            end
            2'd3: begin
                if (!hit)             ex_err = 3'd3;
                else if (diff[VAL_W]) ex_err = 3'd4;
                else begin
                    wr_en  = 1'b1;
                    wr_val = diff[VAL_W-1:0];
                end
            end
            default: ex_err = 3'd5;
        endcase
        ex_sig = (ex_err != 3'd0) ? 2'd3 : (op == 2'd1 ? 2'd1 : 2'd2);
        ex_val = (ex_err != 3'd0) ? (hit ? cur : '0) : wr_val;
    end

    always_ff @(posedge tick_in or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            op       <= '0;
            pkt_key  <= '0;
            pkt_val  <= '0;
            idx      <= '0;
            hit      <= 1'b0;
            hit_idx  <= '0;
            has_free <= 1'b0;
            free_idx <= '0;
            tvalid   <= '0;
            done     <= 1'b0;
            drop     <= 1'b0;
            signal   <= '0;
            err      <= '0;
            key      <= '0;
            value    <= '0;
        end else begin
            done <= 1'b0;
            drop <= newbyt && busy;
            if (state == IDLE && newbyt) begin
                if (op_ok) begin
                    op  <= rx_byte[1:0];
                    cnt <= '0;
                end else begin
                    signal <= 2'd3;
                    err    <= 3'd5;
                    key    <= '0;
                    value  <= '0;
                    done   <= 1'b1;
                end
            end else if (state == COLLECT && newbyt) begin
                {pkt_key, pkt_val} <= {pkt_key[KEY_W-9:0], pkt_val, rx_byte};
                cnt <= cnt + 3'd1;
                if (cnt == 3'd7) begin
                    idx      <= '0;
                    hit      <= 1'b0;
                    has_free <= 1'b0;
                end
            end else if (state == SEARCH) begin
                if (tvalid[idx] && tkey[idx] == pkt_key) begin
                    hit     <= 1'b1;
                    hit_idx <= idx;
                end
                // first free slot seen wins, giving the lowest free index
                if (!tvalid[idx] && !has_free) begin
                    has_free <= 1'b1;
                    free_idx <= idx;
                end
                idx <= idx + IW'(1);
            end else if (state == EXEC) begin
                if (wr_en) tvalid[wr_idx] <= 1'b1;
                done   <= 1'b1;
                signal <= ex_sig;
                err    <= ex_err;
                key    <= pkt_key;
                value  <= ex_val;
            end
        end
    end

    // table payload needs no reset: entries are only read when their valid bit is set
    always_ff @(posedge tick_in) begin
        if (state == EXEC && wr_en) begin
            tkey[wr_idx] <= pkt_key;
            tval[wr_idx] <= wr_val;
        end
    end
endmodule

// File: tb/tb_kv_txn_sequencer.sv
// tb_kv_txn_sequencer: scoreboard bench for kv_txn_sequencer with directed packets.
module tb_kv_txn_sequencer;
    localparam int ENTRIES = 8;

    logic        tick_in = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_byte = 8'h00;
    logic        newbyt = 1'b0;
    logic        busy, drop, done;
    logic [1:0]  signal;
    logic [2:0]  err;
    logic [31:0] key, value;

    kv_txn_sequencer #(.ENTRIES(ENTRIES), .KEY_W(32), .VAL_W(32)) dut (
        .tick_in(tick_in), .rst(rst), .rx_byte(rx_byte), .newbyt(newbyt),
        .busy(busy), .drop(drop), .done(done), .signal(signal),
        .err(err), .key(key), .value(value)
    );

    always #5 tick_in = ~tick_in;

    typedef struct {
        logic [1:0]  sig;
        logic [2:0]  err;
        logic [31:0] key;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last = 0;

    always @(posedge tick_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge tick_in) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("signal", 32'(signal), 32'(e.sig));
                chk("err", 32'(err), 32'(e.err));
                chk("key", key, e.key);
                chk("value", value, e.val);
                chk("done_cycle", cyc, e.cyc);
                chk("busy_in_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge tick_in);
        rx_byte = b;
        newbyt  = 1'b1;
        @(posedge tick_in);
        #1;
        newbyt = 1'b0;
        last   = cyc;
    endtask

    task automatic send_pkt(input logic [7:0] op, input logic [31:0] k, input logic [31:0] v);
        logic [31:0] kk, vv;
        kk = k;
        vv = v;
        send_byte(op);
        for (int i = 3; i >= 0; i--) send_byte(kk[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) send_byte(vv[i*8 +: 8]);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge tick_in);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=pending required=done");
            q.delete();
        end
    endtask

    task automatic txn(input logic [7:0] op, input logic [31:0] k, input logic [31:0] v,
                       input logic [1:0] es, input logic [2:0] ee, input logic [31:0] ev);
        send_pkt(op, k, v);
        q.push_back('{sig: es, err: ee, key: k, val: ev, cyc: last + ENTRIES + 1});
        wait_done();
    endtask

    task automatic bad_op(input logic [7:0] op);
        send_byte(op);
        q.push_back('{sig: 2'd3, err: 3'd5, key: 32'd0, val: 32'd0, cyc: last});
        wait_done();
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_signal"}, 32'(signal), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_key"}, key, 32'd0);
        chk({tag, "_value"}, value, 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge tick_in);
        reset_check("rst0");
        rst = 1'b0;

        txn(8'h01, 32'h10, 32'd500, 2'd1, 3'd0, 32'd500);
        txn(8'h01, 32'h10, 32'd7,   2'd3, 3'd1, 32'd500);
        txn(8'h03, 32'h10, 32'd600, 2'd3, 3'd4, 32'd500);
        txn(8'h03, 32'h10, 32'd500, 2'd2, 3'd0, 32'd0);
        txn(8'h02, 32'h10, 32'd123, 2'd2, 3'd0, 32'd123);
        txn(8'h03, 32'h10, 32'd0,   2'd2, 3'd0, 32'd123);
        txn(8'h01, 32'h20, 32'hFFFFFFFF, 2'd1, 3'd0, 32'hFFFFFFFF);
        txn(8'h02, 32'h20, 32'd1,   2'd3, 3'd6, 32'hFFFFFFFF);
        txn(8'h02, 32'h20, 32'd0,   2'd2, 3'd0, 32'hFFFFFFFF);
        txn(8'h02, 32'h99, 32'd5,   2'd3, 3'd3, 32'd0);
        bad_op(8'h07);
        bad_op(8'h00);

        for (int i = 1; i <= 6; i++) txn(8'h01, 32'h30 + 32'(i), 32'(i), 2'd1, 3'd0, 32'(i));
        txn(8'h01, 32'h40, 32'd9, 2'd3, 3'd2, 32'd0);

        send_pkt(8'h02, 32'h36, 32'd10);
        q.push_back('{sig: 2'd2, err: 3'd0, key: 32'h36, val: 32'd16, cyc: last + ENTRIES + 1});
        @(negedge tick_in);
        chk("busy_search", 32'(busy), 32'd1);
        rx_byte = 8'h01;
        newbyt  = 1'b1;
        @(posedge tick_in);
        #1;
        newbyt = 1'b0;
        @(negedge tick_in);
        chk("drop_pulse", 32'(drop), 32'd1);
        @(negedge tick_in);
        chk("drop_clear", 32'(drop), 32'd0);
        wait_done();
        txn(8'h02, 32'h36, 32'd4, 2'd2, 3'd0, 32'd20);

        send_byte(8'h01);
        for (int i = 0; i < 3; i++) send_byte(8'h00);
        @(negedge tick_in);
        rst = 1'b1;
        #1;
        reset_check("rst_collect");
        @(negedge tick_in);
        rst = 1'b0;
        txn(8'h01, 32'h77, 32'd9, 2'd1, 3'd0, 32'd9);

        send_pkt(8'h01, 32'h78, 32'd1);
        repeat (3) @(negedge tick_in);
        rst = 1'b1;
        #1;
        reset_check("rst_search");
        @(negedge tick_in);
        rst = 1'b0;
        repeat (15) @(negedge tick_in);

        txn(8'h01, 32'h10, 32'd42, 2'd1, 3'd0, 32'd42);
        txn(8'h01, 32'h77, 32'd3,  2'd1, 3'd0, 32'd3);

        repeat (5) @(negedge tick_in);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/kv_txn_sequencer.md
# kv_txn_sequencer

Byte-stream transaction controller for the key-value ledger. Frames incoming bytes into 9-byte packets (opcode, 4-byte key, 4-byte value) and owns a small on-chip account table. It sequences each packet through a table scan and one execute step, then reports the result with a one-cycle `done` pulse. It sits between the byte receiver (the `byte`/`newbyt` source) and downstream status/logging logic, and replaces free-running create capture with a clocked, resettable sequencer.

## Interface
- `ENTRIES`, 8: number of account slots; scan length in cycles.
- `KEY_W`, 32: key width; fixed at 4 bytes.
- `VAL_W`, 32: balance/amount width; fixed at 4 bytes.

- `tick_in`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `byte`  in  8  packet byte, valid when `newbyt`=1.
- `newbyt`  in  1  byte strobe; one byte per cycle it is high.
- `busy`  out  1  high while scanning or executing; bytes are not accepted.
- `drop`  out  1  one-cycle pulse when `newbyt` arrives while `busy`.
- `done`  out  1  one-cycle result pulse.
- `signal`  out  2  result: 0 none, 1 created, 2 transacted, 3 error; held until next `done`.
- `err`  out  3  0 ok, 1 duplicate key, 2 table full, 3 unknown key, 4 insufficient funds, 5 bad opcode, 6 deposit overflow.
- `key`  out  32  key of the last completed packet.
- `value`  out  32  resulting balance; see Operation.

## Operation
- Packet layout: byte0 opcode (0x01 create, 0x02 deposit, 0x03 withdraw), bytes1-4 key MSB first, bytes5-8 value MSB first.
- FSM states:
  - IDLE: waits for an opcode. A valid opcode moves to COLLECT. An invalid opcode produces an immediate result (`signal`=3, `err`=5, `key`=0, `value`=0) and stays in IDLE.
  - COLLECT: counts 8 payload bytes. The 8th byte moves to SEARCH.
  - SEARCH: checks entry i = 0..ENTRIES-1, one entry per cycle. Records the matching index (`valid` && key equal) and the lowest free index.
  - EXEC: applies the packet and registers the outputs, then returns to IDLE.
- Create:
  - If the key matches an entry: err 1.
  - Else if no free entry exists: err 2.
  - Else write the key and balance to the lowest free entry, set `valid`, `signal`=1, `value`=opening balance.
- Deposit:
  - No match: err 3.
  - balance+amount exceeds 2^32-1: err 6, balance unchanged.
  - Otherwise store the sum, `signal`=2, `value`=new balance.
- Withdraw:
  - No match: err 3.
  - amount > balance: err 4, balance unchanged.
  - Otherwise store the difference, `signal`=2, `value`=new balance. A zero result is legal and the entry stays valid.
- On any error: `signal`=3. `value` = current balance if the key was found, else 0. `key` = packet key (0 for bad opcode).
- Arithmetic is 33-bit internally. Stored values are always exactly 32 bits; no wrap is ever stored.
- Gaps between bytes of a packet are allowed; there is no timeout.
- `newbyt` in SEARCH or EXEC: the byte is discarded and `drop` pulses. The in-flight packet is unaffected.
- Reset (any time, including mid-packet or mid-scan):
  - FSM returns to IDLE and the byte count clears.
  - All `valid` bits clear; table contents are don't-care.
  - All outputs go to 0.

## Timing
- Let E0 be the edge that samples payload byte 8.
  - SEARCH occupies edges E1..E(ENTRIES).
  - EXEC registers the outputs at E(ENTRIES+1).
  - `done` is high for the single cycle after E(ENTRIES+1). Latency is ENTRIES+1 cycles; 9 cycles at default.
- `busy` is high from the cycle after E0 through the cycle ending at E(ENTRIES+1). It is low in the `done` cycle, so an opcode presented in the `done` cycle is accepted.
- A bad opcode sampled at edge T updates the outputs at T; `done` is high in the following cycle.
- Back-to-back packets with no idle byte slots: 9 + ENTRIES + 1 cycles per packet minimum.
- Table writes take effect at the EXEC edge and are visible to the next packet's scan.

## Test plan
- Create key 0x00000010, value 500 -> `done` exactly 9 cycles after last byte, `signal`=1, `err`=0, `value`=500.
- Create 0x10 again, value 7 -> `signal`=3, `err`=1, `value`=500. Create 8 distinct keys, then a 9th -> `err`=2.
- Withdraw 600 from 0x10 -> `err`=4, `value`=500. Then withdraw 500 -> `signal`=2, `value`=0.
- Deposit 1 to a key holding 0xFFFFFFFF -> `err`=6, `value`=0xFFFFFFFF. Deposit to unknown key 0x99 -> `err`=3, `value`=0.
- Opcode 0x07 -> `signal`=3, `err`=5 one cycle later. Pulse `newbyt` during SEARCH -> `drop`=1, and the in-flight result is unchanged.
- Assert `rst` mid-COLLECT and mid-SEARCH -> all outputs 0, no `done`. A following create of a previously stored key succeeds, since the table was cleared.
